// File: rtl/csr_loader_pkg.sv
// rtl/csr_loader_pkg.sv - shared widths, words-per-line and FSM state type for the CSR BRAM loader
//
// Purpose : common definitions imported by csr_bram_loader and line_packer.
// Ports   : none (package).

package csr_loader_pkg;

   localparam int DATA_W = 32;
   localparam int LINE_W = 512;
   localparam int ADDR_W = 17;
   localparam int WPL    = LINE_W / DATA_W;
   localparam int IDX_W  = $clog2(WPL);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/csr_bram_loader_packer.sv
// rtl/csr_bram_loader_packer.sv - packs stream words into one BRAM line at a time
//
// Purpose : module line_packer. Collects DATA_W words into a LINE_W pack register,
//           word k landing at bits [DATA_W*k +: DATA_W]. Presents a completed line
//           combinationally with o_line_valid on the beat that fills the last slot,
//           or on a flush request while a partial line is held.
// Ports   : tb_clk        clock
//           reset         synchronous, active-low
//           i_clear       drop any partial line (new load starting)
//           i_beat        accepted stream word this cycle
//           i_word        stream word
//           i_flush       emit the partial line, unused slots zero
//           o_line        line contents including the current beat
//           o_line_valid  o_line is complete and must be written this cycle
//           o_idx         slot the next accepted word will occupy

module line_packer #(
   parameter int DATA_W = csr_loader_pkg::DATA_W,
   parameter int LINE_W = csr_loader_pkg::LINE_W,
   parameter int IDX_W  = $clog2(LINE_W / DATA_W)
) (
   input  logic              tb_clk,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_beat,
   input  logic [DATA_W-1:0] i_word,
   input  logic              i_flush,
   output logic [LINE_W-1:0] o_line,
   output logic              o_line_valid,
   output logic [IDX_W-1:0]  o_idx
);

   import csr_loader_pkg::*;

   localparam int WPL_L = LINE_W / DATA_W;

   logic [IDX_W-1:0]  r_idx;
   logic [LINE_W-1:0] r_pack;
   logic [LINE_W-1:0] w_line;
   logic              w_full;
   logic              w_emit;

   // The pack register is cleared after every emitted line, so slots not yet
   // written are already zero when a short final line is flushed.
   always_comb begin
      w_line = r_pack;
      if (i_beat) begin
         w_line[r_idx*DATA_W +: DATA_W] = i_word;
      end
   end

   assign w_full = i_beat && (r_idx == IDX_W'(WPL_L - 1));
   // r_idx returns to zero once the line is emitted, so a flush fires only once.
   assign w_emit = w_full || (i_flush && (r_idx != '0));

   always_ff @(posedge tb_clk) begin
      if (!reset || i_clear) begin
         r_idx  <= '0;
         r_pack <= '0;
      end else if (w_emit) begin
         r_idx  <= '0;
         r_pack <= '0;
      end else if (i_beat) begin
         r_idx  <= r_idx + IDX_W'(1);
         r_pack <= w_line;
      end
   end

   assign o_line       = w_line;
   assign o_line_valid = w_emit;
   assign o_idx        = r_idx;

endmodule

// File: rtl/csr_bram_loader.sv
// rtl/csr_bram_loader.sv - write side of the 512-bit CSR automaton BRAM
//
// Purpose : accepts a last-marked 32-bit word stream, packs 16 words per line and
//           writes lines to the BRAM from BASE_ADDR upward. Reports done and a
//           sticky error (short or long image) so traversal only starts after a
//           clean load. Optional feature macro: CSR_LOADER_CHECKSUM_EN adds the
//           checksum output (XOR of all words accepted since start).
// Ports   : tb_clk     clock
//           reset      synchronous, active-low
//           start      1-cycle pulse, honoured only in IDLE
//           num_lines  lines to write, sampled on start
//           s_data     stream word
//           s_valid    word valid
//           s_last     final word of image
//           s_ready    loader accepts word
//           wr_addr    BRAM write address
//           wr_data    BRAM write data
//           wr_en      BRAM write strobe, one cycle per line
//           busy       high in LOAD and FLUSH
//           done       1-cycle pulse at load end
//           error      sticky until next start
//           checksum   (CSR_LOADER_CHECKSUM_EN only) XOR of accepted words

module csr_bram_loader #(
   parameter int DATA_W    = csr_loader_pkg::DATA_W,
   parameter int LINE_W    = csr_loader_pkg::LINE_W,
   parameter int ADDR_W    = csr_loader_pkg::ADDR_W,
   parameter int BASE_ADDR = 0
) (
   input  logic              tb_clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] num_lines,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [LINE_W-1:0] wr_data,
   output logic              wr_en,
   output logic              busy,
   output logic              done,
   output logic              error
`ifdef CSR_LOADER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   import csr_loader_pkg::*;

   localparam int WPL_L = LINE_W / DATA_W;
   localparam int IDX_W_L = $clog2(WPL_L);

   state_t              r_state;
   state_t              w_state_nx;
   logic [ADDR_W-1:0]   r_lines;
   logic [ADDR_W-1:0]   r_num;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [LINE_W-1:0]   r_wr_data;
   logic                r_wr_en;
   logic                r_final;
   logic                r_err_pend;
   logic                r_error;

   logic                w_ready;
   logic                w_beat;
   logic                w_flush;
   logic                w_start_ok;
   logic                w_set_final;
   logic                w_err_nx;
   logic [LINE_W-1:0]   w_line;
   logic                w_line_valid;
   logic [IDX_W_L-1:0]  w_idx;
   logic                w_idx_last;
   logic [ADDR_W-1:0]   w_lines_nx;

   // r_final marks that the last line of the image has been handed to the
   // write stage; it closes s_ready for the write cycle so no excess word is taken.
   assign w_ready    = (r_state == LOAD) && !r_final;
   assign w_beat     = s_valid && w_ready;
   assign w_flush    = (r_state == FLUSH);
   assign w_start_ok = start && (r_state == IDLE);
   assign w_idx_last = (w_idx == IDX_W_L'(WPL_L - 1));
   assign w_lines_nx = r_lines + ADDR_W'(1);

   line_packer #(
      .DATA_W (DATA_W),
      .LINE_W (LINE_W),
      .IDX_W  (IDX_W_L)
   ) u_packer (
      .tb_clk       (tb_clk),
      .reset        (reset),
      .i_clear      (w_start_ok),
      .i_beat       (w_beat),
      .i_word       (s_data),
      .i_flush      (w_flush),
      .o_line       (w_line),
      .o_line_valid (w_line_valid),
      .o_idx        (w_idx)
   );

   // Load outcome is decided on the beat that produces the final line; the
   // error value is held in r_err_pend and published on entry to DONE.
   always_comb begin
      w_state_nx  = r_state;
      w_set_final = 1'b0;
      w_err_nx    = r_err_pend;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_err_nx   = 1'b0;
               w_state_nx = (num_lines == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (r_final) begin
               // final line is being written this cycle
               w_state_nx = DONE;
            end else if (w_beat) begin
               if (w_idx_last) begin
                  if (s_last || (w_lines_nx == r_num)) begin
                     w_set_final = 1'b1;
                     // without s_last the image is longer than num_lines
                     w_err_nx    = !s_last || (w_lines_nx != r_num);
                  end
               end else if (s_last) begin
                  w_state_nx = FLUSH;
                  w_err_nx   = (w_lines_nx != r_num);
               end
            end
         end
         FLUSH: begin
            // first FLUSH cycle emits the padded line, second carries its write
            if (r_wr_en) begin
               w_state_nx = DONE;
            end
         end
         DONE: begin
            w_state_nx = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge tb_clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_lines    <= '0;
         r_num      <= '0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_wr_en    <= 1'b0;
         r_final    <= 1'b0;
         r_err_pend <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_wr_en    <= w_line_valid;
         r_err_pend <= w_err_nx;
         if (w_start_ok) begin
            r_num   <= num_lines;
            r_lines <= '0;
            r_final <= 1'b0;
            r_error <= 1'b0;
         end else begin
            if (w_line_valid) begin
               r_wr_data <= w_line;
               // line index wraps modulo 2^ADDR_W by design
               r_wr_addr <= ADDR_W'(BASE_ADDR) + r_lines;
               r_lines   <= w_lines_nx;
            end
            if (w_set_final) begin
               r_final <= 1'b1;
            end
            if ((w_state_nx == DONE) && (r_state != DONE)) begin
               r_error <= w_err_nx;
            end
         end
      end
   end

   assign s_ready = w_ready;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;
   assign wr_en   = r_wr_en;
   assign busy    = (r_state == LOAD) || (r_state == FLUSH);
   assign done    = (r_state == DONE);
   assign error   = r_error;

`ifdef CSR_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] r_checksum;

   always_ff @(posedge tb_clk) begin
      if (!reset) begin
         r_checksum <= '0;
      end else if (w_start_ok) begin
         r_checksum <= '0;
      end else if (w_beat) begin
         r_checksum <= r_checksum ^ s_data;
      end
   end

   assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_csr_bram_loader.sv
// tb/tb_csr_bram_loader.sv - scoreboard bench for csr_bram_loader

module tb_csr_bram_loader;

   localparam int DATA_W = 32;
   localparam int LINE_W = 512;
   localparam int ADDR_W = 17;

   logic              tb_clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] num_lines = '0;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_valid = 1'b0;
   logic              s_last = 1'b0;
   logic              s_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [LINE_W-1:0] wr_data;
   logic              wr_en;
   logic              busy;
   logic              done;
   logic              error;
`ifdef CSR_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
`endif

   int n_pass = 0;
   int n_total = 0;

   logic [ADDR_W-1:0] q_addr[$];
   logic [LINE_W-1:0] q_data[$];
   logic              q_err[$];
   logic [DATA_W-1:0] q_ck[$];

   always #5 tb_clk = ~tb_clk;

   csr_bram_loader dut (
      .tb_clk    (tb_clk),
      .reset     (reset),
      .start     (start),
      .num_lines (num_lines),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_en     (wr_en),
      .busy      (busy),
      .done      (done),
      .error     (error)
`ifdef CSR_LOADER_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail_event(input string name);
      n_total++;
      $display("FAIL %s: event seen with no expectation queued", name);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a write or done.
   always @(negedge tb_clk) begin
      if (reset) begin
         if (wr_en) begin
            if (q_addr.size() == 0) fail_event("unexpected_write");
            else begin
               check("wr_addr", LINE_W'(wr_addr), LINE_W'(q_addr.pop_front()));
               check("wr_data", wr_data, q_data.pop_front());
            end
         end
         if (done) begin
            if (q_err.size() == 0) fail_event("unexpected_done");
            else begin
               logic [DATA_W-1:0] ck_exp;
               ck_exp = q_ck.pop_front();
               check("done_error", LINE_W'(error), LINE_W'(q_err.pop_front()));
`ifdef CSR_LOADER_CHECKSUM_EN
               check("checksum", LINE_W'(checksum), LINE_W'(ck_exp));
`endif
            end
         end
      end
   end

   // Expected lines for words base..base+nwords-1, zero-padded last line;
   // ck is the hand-computed XOR of those words.
   task automatic push_exp(input int nwords, input logic [DATA_W-1:0] base,
                           input logic err, input logic [DATA_W-1:0] ck);
      logic [LINE_W-1:0] line;
      int k;
      int ln;
      line = '0;
      k = 0;
      ln = 0;
      for (int i = 0; i < nwords; i++) begin
         line[k*DATA_W +: DATA_W] = base + DATA_W'(i);
         k++;
         if (k == 16) begin
            q_addr.push_back(ADDR_W'(ln));
            q_data.push_back(line);
            line = '0;
            k = 0;
            ln++;
         end
      end
      if (k != 0) begin
         q_addr.push_back(ADDR_W'(ln));
         q_data.push_back(line);
      end
      q_err.push_back(err);
      q_ck.push_back(ck);
   endtask

   task automatic pulse_start(input int n);
      num_lines = ADDR_W'(n);
      start = 1'b1;
      @(posedge tb_clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_word(input logic [DATA_W-1:0] w, input logic last);
      bit ok;
      ok = 0;
      s_data = w;
      s_last = last;
      s_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(negedge tb_clk);
         if (s_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_total++;
         $display("FAIL ready_timeout: s_ready never rose for word %0h", w);
      end
      @(posedge tb_clk);
      #1;
      s_valid = 1'b0;
      s_last = 1'b0;
   endtask

   task automatic send_range(input int first, input int cnt, input logic [DATA_W-1:0] base, input logic last_on_final);
      for (int i = first; i < first + cnt; i++) begin
         send_word(base + DATA_W'(i), last_on_final && (i == first + cnt - 1));
      end
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge tb_clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         n_total++;
         $display("FAIL %s_done_timeout: done never pulsed", name);
      end else begin
         @(negedge tb_clk);
         check({name, "_done_one_cycle"}, LINE_W'(done), '0);
      end
   endtask

   task automatic check_drained(input string name);
      check({name, "_writes_drained"}, LINE_W'(q_addr.size()), '0);
      check({name, "_dones_drained"}, LINE_W'(q_err.size()), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(posedge tb_clk);
      @(negedge tb_clk);
      check("rst_wr_en", LINE_W'(wr_en), '0);
      check("rst_busy", LINE_W'(busy), '0);
      check("rst_done", LINE_W'(done), '0);
      check("rst_error", LINE_W'(error), '0);
      check("rst_s_ready", LINE_W'(s_ready), '0);
      check("rst_wr_addr", LINE_W'(wr_addr), '0);
      check("rst_wr_data", wr_data, '0);
      reset = 1'b1;
      @(negedge tb_clk);

      // 1) two full lines, s_last on word 31; XOR 0..31 = 0
      push_exp(32, 32'h0, 1'b0, 32'h0);
      pulse_start(2);
      check("t1_busy", LINE_W'(busy), LINE_W'(1));
      send_range(0, 32, 32'h0, 1'b1);
      wait_done("t1");
      check_drained("t1");

      // 2) five words 0xA..0xE, flushed; XOR = 0xE
      push_exp(5, 32'hA, 1'b0, 32'hE);
      pulse_start(1);
      send_range(0, 5, 32'hA, 1'b1);
      wait_done("t2");
      check_drained("t2");

      // 3) short image: 21 words for 3 lines; XOR 0..20 = 0x14
      push_exp(21, 32'h0, 1'b1, 32'h14);
      pulse_start(3);
      send_range(0, 21, 32'h0, 1'b1);
      wait_done("t3");
      check("t3_error_sticky", LINE_W'(error), LINE_W'(1));
      check_drained("t3");

      // 4) long image: 16 accepted words for 1 line, 17th refused; XOR = 0
      push_exp(16, 32'h100, 1'b1, 32'h0);
      pulse_start(1);
      check("t4_error_cleared", LINE_W'(error), '0);
      send_range(0, 16, 32'h100, 1'b0);
      s_data = 32'h110;
      s_valid = 1'b1;
      @(negedge tb_clk);
      check("t4_ready_low_after_final", LINE_W'(s_ready), '0);
      wait_done("t4");
      s_valid = 1'b0;
      check_drained("t4");

      // 5) reset mid-line after 7 beats, then a fresh load from BASE_ADDR
      pulse_start(4);
      send_range(0, 7, 32'h50, 1'b0);
      reset = 1'b0;
      @(posedge tb_clk);
      @(negedge tb_clk);
      check("t5_wr_en", LINE_W'(wr_en), '0);
      check("t5_busy", LINE_W'(busy), '0);
      check("t5_s_ready", LINE_W'(s_ready), '0);
      reset = 1'b1;
      repeat (20) @(negedge tb_clk);
      check_drained("t5_abandon");
      push_exp(16, 32'h200, 1'b0, 32'h0);
      pulse_start(1);
      send_range(0, 16, 32'h200, 1'b1);
      wait_done("t5");
      check_drained("t5");

      // 6) zero-line load, then a start pulsed during a load
      push_exp(0, 32'h0, 1'b0, 32'h0);
      pulse_start(0);
      wait_done("t6a");
      check_drained("t6a");
      push_exp(16, 32'h300, 1'b0, 32'h0);
      pulse_start(1);
      send_range(0, 3, 32'h300, 1'b0);
      pulse_start(5);
      check("t6_busy_after_ignored_start", LINE_W'(busy), LINE_W'(1));
      send_range(3, 13, 32'h300, 1'b1);
      wait_done("t6b");
      check_drained("t6b");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
